// File: rtl/mmio_pkg.sv
// ============================================================================
// Module      : mmio_pkg
// Description : Shared bus command codes, default peripheral bases and the
//               channel slice helper for the MMIO controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    localparam logic [1:0] MCMD_NONE = 2'b00;
    localparam logic [1:0] MWRITE    = 2'b01;
    localparam logic [1:0] MREAD     = 2'b11;

    localparam logic [8:0] DEF_OUT_BASE = 9'h100;
    localparam logic [8:0] DEF_IN_BASE  = 9'h140;

    // LSB of channel k in a flat bus of w-bit channels
    function automatic int chan_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_in_chan.sv
// ============================================================================
// Module      : mmio_in_chan
// Description : One input channel: two-flop synchroniser, previous-value
//               stage, rising-edge detect and write-1-to-clear capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_in_chan #(
    parameter int PORT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PORT_W-1:0] pins,
    input  logic [PORT_W-1:0] clr,
    output logic [PORT_W-1:0] in_sync,
    output logic [PORT_W-1:0] edge_reg
);

    logic [PORT_W-1:0] r_s1;
    logic [PORT_W-1:0] r_s2;
    logic [PORT_W-1:0] r_s3;
    logic [PORT_W-1:0] r_edge;
    logic [PORT_W-1:0] w_rise;

    assign w_rise = r_s2 & ~r_s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_edge <= '0;
        end else begin
            r_s1   <= pins;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            // a fresh rise beats a simultaneous clear of the same bit
            r_edge <= (r_edge & ~clr) | w_rise;
        end
    end

    assign in_sync  = r_s2;
    assign edge_reg = r_edge;

endmodule

`default_nettype wire

// File: rtl/mmio_ctrl.sv
// ============================================================================
// Module      : mmio_ctrl
// Description : Memory-mapped I/O decode: RAM region, N_OUT output registers
//               with readback and N_IN synchronised input channels.
//               Optional MMIO_BUS_ERR_EN adds a sticky unmapped-access flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int              ADDR_W   = 9,
    parameter int              DATA_W   = 16,
    parameter int              PORT_W   = 8,
    parameter int              N_OUT    = 2,
    parameter int              N_IN     = 2,
    parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(DEF_OUT_BASE),
    parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(DEF_IN_BASE)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              mem_cmd,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W-1:0]       ram_dout,
    output logic                    ram_write,
    output logic [DATA_W-1:0]       rdata,
    input  logic [N_IN*PORT_W-1:0]  in_pins,
    output logic [N_OUT*PORT_W-1:0] out_ports
`ifdef MMIO_BUS_ERR_EN
    ,
    output logic                    bus_err
`endif
);

    localparam int c_out_lo = int'(OUT_BASE);
    localparam int c_out_hi = c_out_lo + N_OUT - 1;
    localparam int c_in_lo  = int'(IN_BASE);
    localparam int c_in_hi  = c_in_lo + 2 * N_IN - 1;
    localparam bit c_maps_overlap = (c_out_lo <= c_in_hi) && (c_in_lo <= c_out_hi);

    generate
        if (c_maps_overlap) begin : g_overlap_chk
            $error("mmio_ctrl: output and input register windows overlap");
        end
    endgenerate

    logic                w_ram_sel;
    logic                w_periph_sel;
    logic [N_OUT-1:0]    w_out_hit;
    logic [N_IN-1:0]     w_lvl_hit;
    logic [N_IN-1:0]     w_edge_hit;
    logic                w_any_out_hit;
    logic [PORT_W-1:0]   r_out    [N_OUT];
    logic [PORT_W-1:0]   w_in_sync [N_IN];
    logic [PORT_W-1:0]   w_edge_reg [N_IN];
    logic                w_unused_wdata;

    assign w_ram_sel      = ~mem_addr[ADDR_W-1];
    assign w_periph_sel   = mem_addr[ADDR_W-1];
    assign ram_write      = (mem_cmd == MWRITE) & w_ram_sel;
    assign w_any_out_hit  = |w_out_hit;
    assign w_unused_wdata = ^wdata;

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_out
            localparam logic [ADDR_W-1:0] c_addr = ADDR_W'(c_out_lo + k);

            assign w_out_hit[k] = w_periph_sel & (mem_addr == c_addr);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_out[k] <= '0;
                end else if ((mem_cmd == MWRITE) && w_out_hit[k]) begin
                    r_out[k] <= wdata[PORT_W-1:0];
                end
            end

            assign out_ports[chan_lsb(k, PORT_W) +: PORT_W] = r_out[k];
        end

        for (genvar k = 0; k < N_IN; k++) begin : g_in
            localparam logic [ADDR_W-1:0] c_lvl_addr  = ADDR_W'(c_in_lo + 2 * k);
            localparam logic [ADDR_W-1:0] c_edge_addr = ADDR_W'(c_in_lo + 2 * k + 1);
            logic [PORT_W-1:0] w_clr;

            // output registers win if a bad configuration makes windows overlap
            assign w_lvl_hit[k]  = w_periph_sel & ~w_any_out_hit & (mem_addr == c_lvl_addr);
            assign w_edge_hit[k] = w_periph_sel & ~w_any_out_hit & (mem_addr == c_edge_addr);
            assign w_clr = ((mem_cmd == MWRITE) && w_edge_hit[k]) ? wdata[PORT_W-1:0] : '0;

            mmio_in_chan #(
                .PORT_W (PORT_W)
            ) u_in_chan (
                .clk      (clk),
                .reset_n  (reset_n),
                .pins     (in_pins[chan_lsb(k, PORT_W) +: PORT_W]),
                .clr      (w_clr),
                .in_sync  (w_in_sync[k]),
                .edge_reg (w_edge_reg[k])
            );
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (mem_cmd == MREAD) begin
            if (w_ram_sel) begin
                rdata = ram_dout;
            end
            for (int k = 0; k < N_IN; k++) begin
                if (w_lvl_hit[k]) begin
                    rdata = DATA_W'(w_in_sync[k]);
                end
                if (w_edge_hit[k]) begin
                    rdata = DATA_W'(w_edge_reg[k]);
                end
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (w_out_hit[k]) begin
                    rdata = DATA_W'(r_out[k]);
                end
            end
        end
    end

`ifdef MMIO_BUS_ERR_EN
    logic w_access;
    logic w_mapped;
    logic r_bus_err;

    assign w_access = (mem_cmd == MREAD) || (mem_cmd == MWRITE);
    assign w_mapped = w_any_out_hit | (|w_lvl_hit) | (|w_edge_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_err <= 1'b0;
        end else if (w_access && w_periph_sel && !w_mapped) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`endif

endmodule

`default_nettype wire
